// File: rtl/omsp_sm_ctrl_seq.sv
// omsp_sm_ctrl_seq: table-based secure-module controller with sequential overlap scan (option SM_VIOL_LATCH_EN makes violation sticky)
module omsp_sm_ctrl_seq #(
  parameter int NB_SM  = 4,
  parameter int ID_W   = 16,
  parameter int ADDR_W = 16
) (
  input  logic              mclk,
  input  logic              puc_rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] eu_mab,
  input  logic              eu_mb_en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] pub_start,
  input  logic [ADDR_W-1:0] pub_end,
  input  logic [ADDR_W-1:0] sec_start,
  input  logic [ADDR_W-1:0] sec_end,
  output logic              rsp_valid,
  output logic              rsp_ok,
  output logic [ID_W-1:0]   rsp_id,
  output logic [ID_W-1:0]   current_id,
  output logic [ID_W-1:0]   prev_id,
  output logic              violation,
  input  logic              violation_clr
);
  localparam int IW = NB_SM > 1 ? $clog2(NB_SM) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB_SM - 1);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t state, state_n;
  logic [NB_SM-1:0] vld;
  logic [ID_W-1:0] sid [NB_SM];
  logic [ADDR_W-1:0] ps [NB_SM];
  logic [ADDR_W-1:0] pe [NB_SM];
  logic [ADDR_W-1:0] ss [NB_SM];
  logic [ADDR_W-1:0] se [NB_SM];
  logic [ADDR_W-1:0] nps, npe, nss, nse, prev_pc;
  logic [ID_W-1:0] next_id, prev_cycle_id;
  logic [IW-1:0] idx, fidx, fidx_n, didx, cur_idx;
  logic op, ovl, ovl_n, ffound, ffound_n, hit, create_ok, raw;
  function automatic logic ov(input logic [ADDR_W-1:0] a, b, c, d);
    return a < d && c < b;
  endfunction
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // next state: create scans every slot, destroy answers immediately
  always_comb begin
    state_n = state == IDLE ? (cmd_valid ? (cmd_op ? RESP : SCAN) : IDLE) :
              state == SCAN ? (idx == LAST ? RESP : SCAN) : IDLE;
  end
  // per-slot overlap/free-slot step and final create verdict
  always_comb begin
    hit = vld[idx] & (ov(nps, npe, ps[idx], pe[idx]) | ov(nps, npe, ss[idx], se[idx]) |
                      ov(nss, nse, ps[idx], pe[idx]) | ov(nss, nse, ss[idx], se[idx]));
    ovl_n = ovl | hit;
    ffound_n = ffound | ~vld[idx];
    fidx_n = (ffound | vld[idx]) ? fidx : idx;
    create_ok = nps < npe && nss < nse && !ov(nps, npe, nss, nse) && !ovl_n && ffound_n && next_id != '0;
  end
  // executing module lookup (lowest index wins) and raw violation detection
  always_comb begin
    current_id = '0;
    cur_idx = '0;
    raw = 1'b0;
    for (int s = NB_SM - 1; s >= 0; s--)
      if (vld[s] && ps[s] <= pc && pc < pe[s]) begin
        current_id = sid[s];
        cur_idx = IW'(s);
      end
    for (int s = 0; s < NB_SM; s++)
      raw = raw | (vld[s] & ((eu_mb_en & ss[s] <= eu_mab & eu_mab < se[s] & current_id != sid[s]) |
                             (ps[s] <= pc & pc < pe[s] & !(ps[s] <= prev_pc & prev_pc < pe[s]) & pc != ps[s])));
  end
  // command sequencing, table updates and execution history
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state <= IDLE;
      idx <= '0;
      fidx <= '0;
      didx <= '0;
      ovl <= 1'b0;
      ffound <= 1'b0;
      op <= 1'b0;
      nps <= '0;
      npe <= '0;
      nss <= '0;
      nse <= '0;
      rsp_ok <= 1'b0;
      rsp_id <= '0;
      next_id <= ID_W'(1);
      vld <= '0;
      prev_pc <= '0;
      prev_cycle_id <= '0;
      prev_id <= '0;
      for (int s = 0; s < NB_SM; s++) begin
        sid[s] <= '0;
        ps[s] <= '0;
        pe[s] <= '0;
        ss[s] <= '0;
        se[s] <= '0;
      end
    end else begin
      state <= state_n;
      prev_pc <= pc;
      prev_cycle_id <= current_id;
      if (prev_cycle_id != current_id) prev_id <= prev_cycle_id;
      if (state == IDLE && cmd_valid) begin
        op <= cmd_op;
        nps <= pub_start;
        npe <= pub_end;
        nss <= sec_start;
        nse <= sec_end;
        idx <= '0;
        fidx <= '0;
        ovl <= 1'b0;
        ffound <= 1'b0;
        if (cmd_op) begin
          rsp_ok <= current_id != '0;
          rsp_id <= current_id;
          didx <= cur_idx;
        end
      end
      if (state == SCAN) begin
        idx <= idx == LAST ? '0 : idx + 1'b1;
        ovl <= ovl_n;
        ffound <= ffound_n;
        fidx <= fidx_n;
        if (idx == LAST) begin
          rsp_ok <= create_ok;
          rsp_id <= create_ok ? next_id : '0;
        end
      end
      if (state == RESP && rsp_ok) begin
        if (op) vld[didx] <= 1'b0;
        else begin
          vld[fidx] <= 1'b1;
          sid[fidx] <= next_id;
          ps[fidx] <= nps;
          pe[fidx] <= npe;
          ss[fidx] <= nss;
          se[fidx] <= nse;
          next_id <= next_id + 1'b1;
        end
      end
    end
  end
`ifdef SM_VIOL_LATCH_EN
  // sticky violation: a new event wins over a simultaneous clear
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) violation <= 1'b0;
    else violation <= raw ? 1'b1 : violation_clr ? 1'b0 : violation;
  end
`else
  logic unused_clr;
  assign unused_clr = violation_clr;
  assign violation = raw;
`endif
endmodule

// File: doc/omsp_sm_ctrl_seq.md
Name: omsp_sm_ctrl_seq

Overview:
- Parametrised, table-based successor to the per-module protection controller.
- Holds NB_SM secure-module slots internally. Checks overlap for new modules with a sequential slot scan instead of a parallel array.
- Serialises create/destroy commands through a ready/valid handshake, allocates IDs, and tracks the current and previous executing module IDs.
- Flags memory-access and entry-point violations. Sits between the execution unit and the frontend.

Parameters:
NB_SM, 4, number of module slots (1..16)
ID_W, 16, width of module IDs and the ID counter
ADDR_W, 16, width of pc, eu_mab and section bounds

Ports:
mclk  in  1  core clock
puc_rst_n  in  1  asynchronous active-low reset
pc  in  ADDR_W  current program counter
eu_mab  in  ADDR_W  execution-unit memory address
eu_mb_en  in  1  execution-unit memory access strobe
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  1  0=create, 1=destroy
pub_start, pub_end, sec_start, sec_end  in  ADDR_W each  create operands, half-open ranges [start,end)
rsp_valid  out  1  one-cycle response pulse
rsp_ok  out  1  command succeeded
rsp_id  out  ID_W  ID created or destroyed; 0 on failure
current_id  out  ID_W  ID of the module whose public section contains pc; 0 if none
prev_id  out  ID_W  last different value of current_id
violation  out  1  protection violation
violation_clr  in  1  clear for the sticky violation (optional feature only)

Behaviour:
- Reset (async, puc_rst_n=0):
  - All slots invalid; next_id=1; FSM=IDLE; prev_pc=0.
  - Outputs: cmd_ready=1, rsp_valid=0, rsp_ok=0, rsp_id=0, prev_id=0, violation=0. current_id=0 follows from empty slots.
  - Reset mid-command aborts the command; no response is issued.
- FSM states: IDLE, SCAN, RESP.
  - Accept condition: cmd_valid & cmd_ready at edge k; operands are latched at that edge.
  - cmd_valid outside IDLE is ignored.
- Create path:
  - IDLE→SCAN. Slot index i goes 0..NB_SM-1, one slot per cycle, cycles k+1..k+NB_SM.
  - Each cycle records overlap of either new section with either section of valid slot i (4 interval compares).
  - Each cycle also records the lowest-index invalid slot.
  - After the last slot, go to RESP. rsp_valid is high in cycle k+NB_SM+1; then IDLE.
  - Success requires all of: pub_start<pub_end, sec_start<sec_end, new sections mutually disjoint, no overlap, a free slot exists, next_id≠0.
  - On success: write the slot, rsp_ok=1, rsp_id=next_id, next_id+=1 (ID_W wrap).
  - On failure: rsp_ok=0, rsp_id=0, table and next_id unchanged.
- ID exhaustion: next_id==0 after wrap makes every later create fail until reset. IDs are never reused.
- Destroy path:
  - IDLE→RESP; rsp_valid in cycle k+1.
  - If current_id≠0 at accept: invalidate the executing slot, rsp_ok=1, rsp_id=that ID.
  - Otherwise rsp_ok=0, rsp_id=0.
- rsp_ok and rsp_id hold their value until the next response; they are meaningful only when rsp_valid=1.
- current_id: combinational; lowest-index valid slot with pub_start≤pc<pub_end.
- prev_pc and prev_cycle_id are registered every cycle. prev_id loads prev_cycle_id when prev_cycle_id≠current_id.
- Raw violation (combinational, per cycle):
  - Data violation: eu_mb_en and eu_mab inside the secret section of valid slot s, while current_id≠id[s].
  - Entry violation: pc inside the public section of slot s, prev_pc outside it, and pc≠pub_start[s].
- The table write at commit takes effect at the RESP edge. Checks use the registered table, so a module is protected from cycle k+NB_SM+2 onward.

Optional Feature:
SM_VIOL_LATCH_EN
- Defined: violation is a register, set by raw violation and cleared by violation_clr. Set has priority when both occur in the same cycle. Visible one cycle after the event.
- Undefined: violation = raw violation, combinational; violation_clr is ignored.

Test Plan:
- NB_SM=4, create pub [0x8000,0x8100) sec [0x0300,0x0340) → rsp_valid at cycle k+5, rsp_ok=1, rsp_id=1; pc=0x8000 → current_id=1.
- Second create with sec [0x0320,0x0380) overlapping slot 0 → rsp_ok=0, rsp_id=0; next create succeeds with rsp_id=2.
- pc=0x4000, eu_mb_en=1, eu_mab=0x0310 → violation=1. Same access with pc=0x8010 after entering at 0x8000 → violation=0.
- Jump from pc=0x4000 to 0x8010 → violation=1. Latch build: stays 1 until violation_clr; clr with a simultaneous violation keeps 1.
- Destroy with pc=0x8020 → rsp_ok=1, rsp_id=1, slot freed; destroy with pc=0x4000 → rsp_ok=0.
- ID_W=2: three successful creates (IDs 1,2,3), next_id wraps to 0 → fourth create fails with rsp_id=0; assert puc_rst_n mid-SCAN → no rsp_valid, cmd_ready=1, table empty.
